// File: rtl/sprite_arb_pkg.sv
// Shared types and default parameter values for the sprite ROM arbiter.
package sprite_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ROM_LAT   = 1;
    localparam int DEF_MAX_BURST = 8;
    localparam int STAT_W        = 16;

endpackage

// File: rtl/sprite_rr_pick.sv
// Round-robin picker: returns the first requester found at or after (last_i + 1), wrapping.
module sprite_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic               valid_o
);

    logic [ID_W-1:0] idx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_i) + k) % NUM_REQ);
            if (!valid_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among NUM_REQ readers with burst limiting.
// Defining SPRITE_ARB_STATS_EN adds per-requester saturating grant counters on grant_cnt.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROM_LAT   = DEF_ROM_LAT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [DATA_W-1:0]          rom_q,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_data
`ifdef SPRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]  grant_cnt
`endif
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rsp_tag_t;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    rsp_tag_t           pipe_q [ROM_LAT];

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic               others_pending;
    logic               keep;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    sprite_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = ID_W'(i);
        end
    end

    // The owner keeps the ROM until it lets go, or until its burst is spent while someone waits.
    assign others_pending = |(req & ~gnt_q);
    assign keep = (state_q == OWN) && req[last_q] &&
                  !((burst_q == BURST_MAX) && others_pending);

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        last_d     = last_q;
        burst_d    = burst_q;
        rom_addr_d = rom_addr_q;
        if (keep) begin
            gnt_d      = gnt_q;
            rom_addr_d = addr_arr[last_q];
            if (burst_q != BURST_MAX) burst_d = burst_q + BURST_W'(1);
        end else if (pick_valid) begin
            state_d    = OWN;
            gnt_d      = pick;
            last_d     = pick_idx;
            burst_d    = BURST_W'(1);
            rom_addr_d = addr_arr[pick_idx];
        end else begin
            state_d = IDLE;
            burst_d = '0;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            burst_q    <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // NOTE: the tag pipeline is reset so a reset drops every in-flight response at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{valid: |gnt_q, id: (|gnt_q) ? last_q : '0};
            for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign gnt       = gnt_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = pipe_q[ROM_LAT-1].valid;
    assign rsp_id    = pipe_q[ROM_LAT-1].id;
    assign rsp_data  = pipe_q[ROM_LAT-1].valid ? rom_q : '0;

`ifdef SPRITE_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_q[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + STAT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: random and directed request patterns against a
// cycle-level round-robin model; responses are matched by a separate monitor.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 4;
    localparam int ROM_LAT   = 2;
    localparam int MAX_BURST = 8;
    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int BOUND     = (NUM_REQ - 1) * MAX_BURST;

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_q;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
`ifdef SPRITE_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

    always #5 Clk = ~Clk;

    sprite_rom_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_LAT   (ROM_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef SPRITE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] x;
        x = a ^ (a >> 4) ^ (a >> 8) ^ ADDR_W'(5);
        return x[DATA_W-1:0];
    endfunction

    // ROM model: data for an address appears ROM_LAT cycles after it is presented.
    logic [ADDR_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_fn(rom_pipe[ROM_LAT-1]);

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_rsp_t;
    exp_rsp_t sb[$];

    // Reference model state: who owns the ROM, how long it has held it, who was served last.
    bit                m_busy;
    int                m_owner;
    int                m_last;
    int                m_run;
    logic [ADDR_W-1:0] m_addr;
    int                wait_cnt [NUM_REQ];

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NUM_REQ - 1;
        m_run   = 0;
        m_addr  = '0;
        sb.delete();
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [NUM_REQ-1:0] r, output logic [NUM_REQ-1:0] g,
                              output int gi);
        bit others;
        others = 1'b0;
        g  = '0;
        gi = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i] && !(m_busy && i == m_owner)) others = 1'b1;
        end
        if (m_busy && r[m_owner] && (m_run < MAX_BURST || !others)) begin
            gi = m_owner;
            if (m_run < MAX_BURST) m_run++;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (gi < 0 && r[(m_last + k) % NUM_REQ]) gi = (m_last + k) % NUM_REQ;
            end
            if (gi >= 0) begin
                m_owner = gi;
                m_last  = gi;
                m_busy  = 1'b1;
                m_run   = 1;
            end else begin
                m_busy = 1'b0;
                m_run  = 0;
            end
        end
        if (gi >= 0) begin
            g[gi]  = 1'b1;
            m_addr = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endtask

    function automatic logic [NUM_REQ*ADDR_W-1:0] rand_addrs();
        logic [NUM_REQ*ADDR_W-1:0] a;
        for (int i = 0; i < NUM_REQ; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        return a;
    endfunction

    // One clock: drive inputs, predict, step past the edge, then check grant-side outputs.
    task automatic cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*ADDR_W-1:0] a);
        logic [NUM_REQ-1:0] g;
        int gi;
        req      = r;
        req_addr = a;
        model_step(r, g, gi);
        @(posedge Clk);
        #1;
        check("gnt", gnt, g);
        check("rom_addr", rom_addr, m_addr);
        if (gi >= 0) sb.push_back('{gi, rom_fn(m_addr), cyc + ROM_LAT});
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                check("wait_bound", wait_cnt[i] <= BOUND, 1);
                wait_cnt[i] = 0;
            end else if (r[i]) begin
                wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
        end
    endtask

    task automatic pulse_reset();
        req   = '0;
        Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Monitor: every presented response must match the oldest expected one, on its due cycle.
    initial begin
        exp_rsp_t e;
        forever begin
            @(negedge Clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, want none (cycle %0d)",
                             rsp_id, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_time", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rsp_missing", rsp_valid, 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0]        r;
        logic [NUM_REQ*ADDR_W-1:0] a;

        Reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        model_reset();
        @(posedge Clk);
        #1;
        check("reset_gnt", gnt, '0);
        check("reset_rom_addr", rom_addr, '0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_id", rsp_id, '0);
        check("reset_rsp_data", rsp_data, '0);
`ifdef SPRITE_ARB_STATS_EN
        check("reset_grant_cnt", grant_cnt, '0);
`endif
        Reset = 1'b0;

        // Single requester: grant next cycle, response ROM_LAT cycles later.
        a = rand_addrs();
        a[0 +: ADDR_W] = 12'h040;
        cycle(4'b0001, a);
        check("single_gnt", gnt, 4'b0001);
        check("single_addr", rom_addr, 12'h040);
        cycle(4'b0000, rand_addrs());
        repeat (ROM_LAT + 2) cycle(4'b0000, rand_addrs());

        // All requesting: bursts of MAX_BURST in index order, wrapping, no idle cycles.
        pulse_reset();
        for (int t = 0; t < NUM_REQ * MAX_BURST + MAX_BURST; t++) begin
            cycle(4'b1111, rand_addrs());
            check("rr_seq", gnt, NUM_REQ'(1) << ((t / MAX_BURST) % NUM_REQ));
        end

        // Owner 2 lets go on its third cycle with 3 waiting: handover with no gap.
        pulse_reset();
        cycle(4'b0000, rand_addrs());
        cycle(4'b0100, rand_addrs());
        cycle(4'b1100, rand_addrs());
        cycle(4'b1100, rand_addrs());
        check("owner2_held", gnt, 4'b0100);
        cycle(4'b1000, rand_addrs());
        check("handover", gnt, 4'b1000);
        for (int t = 0; t < 3; t++) begin
            check("no_gap", rsp_valid, 1'b1);
            cycle(4'b1000, rand_addrs());
        end
        repeat (ROM_LAT + 2) cycle(4'b0000, rand_addrs());

        // Reset with two responses in flight.
        pulse_reset();
        repeat (5) cycle(4'b1111, rand_addrs());
        #2;
        Reset = 1'b1;
        req   = '0;
        model_reset();
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_gnt", gnt, '0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int t = 0; t < ROM_LAT + 2; t++) begin
            cycle(4'b0000, rand_addrs());
            check("post_rst_quiet", rsp_valid, 1'b0);
        end
        cycle(4'b1111, rand_addrs());
        check("post_rst_first", gnt, 4'b0001);
        repeat (ROM_LAT + 2) cycle(4'b0000, rand_addrs());

        // Random phase: request sets held for random stretches.
        r = '0;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) r = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            cycle(r, rand_addrs());
        end
        repeat (ROM_LAT + 2) cycle(4'b0000, rand_addrs());

`ifdef SPRITE_ARB_STATS_EN
        pulse_reset();
        for (int t = 0; t < 70000; t++) cycle(4'b0010, rand_addrs());
        cycle(4'b0000, rand_addrs());
        check("stat_cnt1_sat", grant_cnt[16 +: 16], 16'hFFFF);
        check("stat_cnt0", grant_cnt[0 +: 16], 16'h0000);
        check("stat_cnt2", grant_cnt[32 +: 16], 16'h0000);
        check("stat_cnt3", grant_cnt[48 +: 16], 16'h0000);
        repeat (ROM_LAT + 2) cycle(4'b0000, rand_addrs());
`endif

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 12, SHALL set the sprite ROM address width.
REQ-003 Parameter DATA_W, default 4, SHALL set the ROM palette-index width.
REQ-004 Parameter ROM_LAT, default 1, SHALL set the ROM read latency in cycles (1..2).
REQ-005 Parameter MAX_BURST, default 8, SHALL set the maximum consecutive grants to one requester while others wait.
REQ-006 Port Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-008 Port req  input  NUM_REQ  SHALL carry per-requester read requests.
REQ-009 Port req_addr  input  NUM_REQ*ADDR_W  SHALL carry the packed request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 Port gnt  output  NUM_REQ  SHALL be a one-hot-or-zero grant vector for the current cycle.
REQ-011 Port rom_addr  output  ADDR_W  SHALL drive the shared sprite ROM address.
REQ-012 Port rom_q  input  DATA_W  SHALL return ROM data ROM_LAT cycles after rom_addr.
REQ-013 Port rsp_valid  output  1  SHALL flag valid returned data.
REQ-014 Port rsp_id  output  $clog2(NUM_REQ)  SHALL identify the requester owning rsp_data.
REQ-015 Port rsp_data  output  DATA_W  SHALL carry rom_q for the flagged requester.

Function
REQ-016 gnt SHALL be registered; a request seen at edge N SHALL at the earliest be granted in the cycle after edge N.
REQ-017 rom_addr SHALL equal req_addr of the granted requester, registered alongside gnt; when no grant is active it SHALL hold its last value.
REQ-018 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NUM_REQ and wraps.
REQ-019 FSM states IDLE and OWN: IDLE -> OWN when any req is high; OWN -> IDLE when no req is high; OWN -> OWN (new owner) on rotation.
REQ-020 In OWN, the current owner SHALL keep gnt while its req stays high, until burst count reaches MAX_BURST with another req pending; then grant SHALL rotate next cycle.
REQ-021 Burst counter SHALL reset to 1 on every new grant, increment per granted cycle, and saturate at MAX_BURST when no other requester waits.
REQ-022 Owner dropping req SHALL release the grant on the next edge; if others pend, rotation occurs in that same edge with no idle cycle.
REQ-023 Every granted cycle SHALL push {valid, id} into a ROM_LAT-deep shift pipeline; rsp_valid/rsp_id SHALL emerge exactly ROM_LAT cycles after gnt, with rsp_data = rom_q in that cycle.
REQ-024 One ROM access per cycle; throughput SHALL be one response per cycle when any req is continuously high.
REQ-025 A requester SHALL never wait more than (NUM_REQ-1)*MAX_BURST cycles after asserting req.

Reset
REQ-026 On Reset: state=IDLE, gnt=0, rom_addr=0, last-granted index=NUM_REQ-1 (so requester 0 wins first), burst count=0, pipeline cleared, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-027 Reset mid-burst SHALL immediately clear all in-flight responses; no rsp_valid for pre-reset grants SHALL appear.

Configuration
REQ-028 Macro SPRITE_ARB_STATS_EN defined: add output grant_cnt (NUM_REQ*16 bits), per-requester 16-bit saturating grant counters, cleared by Reset.
REQ-029 Macro SPRITE_ARB_STATS_EN undefined: grant_cnt port and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package sprite_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-031 Round-robin pick logic SHALL be a sub-module sprite_rr_pick (inputs req, last index; outputs one-hot pick, valid).

Verification
REQ-032 Reset then req=4'b0001, addr0=12'h040 -> gnt=0001 next cycle, rom_addr=12'h040, rsp_valid with rsp_id=0 ROM_LAT cycles later.
REQ-033 req=4'b1111 held, MAX_BURST=8 -> grants 0 for 8 cycles, then 1,2,3 for 8 each, wrapping to 0; no idle cycles.
REQ-034 Owner 2 drops req at cycle 3 of burst with req3 pending -> gnt=1000 on next edge, no gap in rsp_valid.
REQ-035 Reset asserted while 2 responses in flight (ROM_LAT=2) -> rsp_valid=0 immediately and stays 0 after release until new grant.
REQ-036 SPRITE_ARB_STATS_EN defined, requester 1 granted 70000 cycles -> its grant_cnt saturates at 16'hFFFF; others unchanged.
